fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain.sv | 104 ++++++++++
 tb/tb_fifo_drain.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// -----------------------------------------------------------------------------
// fifo_drain
// Pulls words out of a FIFO one at a time and presents each one to a
// downstream valid/ready consumer. Each word costs a read strobe (FETCH),
// a cycle for the RAM read data to arrive (LOAD) and at least one cycle
// of presentation (PRESENT). The best case is 3 cycles per word.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   enable     : allows a new fetch to start (never aborts one in flight)
//   empty      : FIFO empty flag, only looked at when deciding to fetch
//   fifo_rdata : FIFO RAM read data, valid the cycle after read
//   read       : one-cycle read strobe to the FIFO control
//   out_data   : registered word presented downstream
//   out_valid  : out_data holds a word that has not been delivered yet
//   out_ready  : downstream accepts out_data while out_valid is high
//   busy       : high whenever the engine is not idle
//   word_count : words delivered since reset, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fifo_drain #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              read,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      LOAD    = 2'd2,
      PRESENT = 2'd3
   } state_t;

   state_t            state_r;
   logic [DATA_W-1:0] data_r;
   logic [CNT_W-1:0]  count_r;
   logic              fetch_ok;

   // A new fetch may start only while enabled and the FIFO has a word.
   assign fetch_ok = enable && !empty;

   // Sequencer, output word register and delivered-word counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         data_r  <= '0;
         count_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (fetch_ok) begin
                  state_r <= FETCH;
               end else begin
                  state_r <= IDLE;
               end
            end
            FETCH: begin
               state_r <= LOAD;
            end
            LOAD: begin
               // RAM data answers the strobe issued during FETCH.
               data_r  <= fifo_rdata;
               state_r <= PRESENT;
            end
            PRESENT: begin
               if (out_ready) begin
                  count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  // Chain straight into the next word when one is available.
                  if (fetch_ok) begin
                     state_r <= FETCH;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= PRESENT;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Control outputs are pure decodes of the state register, so they are
   // glitch-free and change only on the clock edge.
   assign read       = (state_r == FETCH);
   assign out_valid  = (state_r == PRESENT);
   assign busy       = (state_r != IDLE);
   assign out_data   = data_r;
   assign word_count = count_r;

endmodule

// File: tb/tb_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain
// Directed bench for fifo_drain. A small FIFO model answers read strobes
// with data one cycle later. A second instance with CNT_W=2 shares all
// inputs and exercises counter wrap. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_drain;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       empty;
   logic       out_ready;
   logic [7:0] fifo_rdata = 8'hEE;
   logic       read;
   logic [7:0] out_data;
   logic       out_valid;
   logic       busy;
   logic [7:0] word_count;
   logic       read2;
   logic [7:0] out_data2;
   logic       out_valid2;
   logic       busy2;
   logic [1:0] word_count2;

   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         reads  = 0;
   int         tests  = 0;
   int         fails  = 0;
   int         r0;
   int         n;

   always #5 clk = ~clk;

   fifo_drain #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .empty(empty),
      .fifo_rdata(fifo_rdata), .read(read), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .word_count(word_count)
   );

   fifo_drain #(.DATA_W(8), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .empty(empty),
      .fifo_rdata(fifo_rdata), .read(read2), .out_data(out_data2),
      .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2),
      .word_count(word_count2)
   );

   // FIFO model: the bench pushes on the falling edge, a strobe pops on the
   // rising edge and the popped word sits on fifo_rdata for the next cycle.
   assign empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (read) begin
         fifo_rdata <= mem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
         reads      <= reads + 1;
      end else begin
         fifo_rdata <= 8'hEE;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr] = d;
      wr_ptr++;
   endtask

   // Wait (bounded) until a word is presented; returns cycles waited.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 12) begin
         step();
         cycles++;
      end
      check("valid_seen", 32'(out_valid), 32'd1);
   endtask

   // Expect a presented word, let it hand off, then check both counters.
   task automatic deliver(input string tag, input logic [7:0] d,
                          input logic [7:0] cnt, input logic [1:0] cnt2);
      check({tag, "_data"}, 32'(out_data), 32'(d));
      check({tag, "_data2"}, 32'(out_data2), 32'(d));
      step();
      check({tag, "_cnt"}, 32'(word_count), 32'(cnt));
      check({tag, "_cnt2"}, 32'(word_count2), 32'(cnt2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      out_ready = 1'b0;
      repeat (3) step();
      check("rst_read",  32'(read),       32'd0);
      check("rst_valid", 32'(out_valid),  32'd0);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_data",  32'(out_data),   32'd0);
      check("rst_cnt",   32'(word_count), 32'd0);
      reset = 1'b0;
      step();

      // Single word with latency: IDLE edge t, read at t+1, valid at t+3.
      push(8'hA5);
      enable    = 1'b1;
      out_ready = 1'b1;
      r0 = reads;
      step();
      check("t1_read_fetch", 32'(read), 32'd1);
      check("t1_busy_fetch", 32'(busy), 32'd1);
      check("t1_valid_fetch", 32'(out_valid), 32'd0);
      step();
      check("t1_read_load", 32'(read), 32'd0);
      check("t1_valid_load", 32'(out_valid), 32'd0);
      step();
      check("t1_valid_present", 32'(out_valid), 32'd1);
      deliver("t1", 8'hA5, 8'd1, 2'd1);
      check("t1_valid_after", 32'(out_valid), 32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);
      check("t1_reads", 32'(reads - r0), 32'd1);

      // Back-pressure: first word held for 10 cycles, only one strobe.
      out_ready = 1'b0;
      push(8'h11);
      push(8'h22);
      r0 = reads;
      wait_valid(n);
      repeat (10) step();
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_data_held", 32'(out_data), 32'h11);
      check("bp_reads", 32'(reads - r0), 32'd1);
      out_ready = 1'b1;
      deliver("bp_w1", 8'h11, 8'd2, 2'd2);
      wait_valid(n);
      deliver("bp_w2", 8'h22, 8'd3, 2'd3);

      // Drain five words back to back, 3 cycles apart, then stop.
      push(8'h10); push(8'h20); push(8'h30); push(8'h40); push(8'h50);
      r0 = reads;
      for (int i = 0; i < 5; i++) begin
         wait_valid(n);
         if (i > 0) check("drain_spacing", 32'(n), 32'd2);
         deliver("drain", 8'(8'h10 * (i + 1)), 8'(4 + i), 2'(4 + i));
      end
      repeat (5) step();
      check("drain_reads", 32'(reads - r0), 32'd5);
      check("drain_busy", 32'(busy), 32'd0);
      check("drain_empty", 32'(empty), 32'd1);

      // Enable drops during LOAD of word 1: it completes, nothing more.
      push(8'h61); push(8'h62); push(8'h63);
      r0 = reads;
      step();
      step();
      enable = 1'b0;
      step();
      check("ed_valid", 32'(out_valid), 32'd1);
      deliver("ed_w1", 8'h61, 8'd9, 2'd1);
      check("ed_busy", 32'(busy), 32'd0);
      repeat (4) step();
      check("ed_reads", 32'(reads - r0), 32'd1);
      check("ed_left", 32'(wr_ptr - rd_ptr), 32'd2);
      enable = 1'b1;
      wait_valid(n);
      deliver("ed_w2", 8'h62, 8'd10, 2'd2);
      wait_valid(n);
      deliver("ed_w3", 8'h63, 8'd11, 2'd3);

      // Reset in PRESENT coinciding with a handshake.
      out_ready = 1'b0;
      push(8'h3C);
      wait_valid(n);
      check("rp_data", 32'(out_data), 32'h3C);
      r0 = reads;
      reset     = 1'b1;
      out_ready = 1'b1;
      step();
      check("rp_valid", 32'(out_valid), 32'd0);
      check("rp_cnt", 32'(word_count), 32'd0);
      check("rp_busy", 32'(busy), 32'd0);
      check("rp_read", 32'(read), 32'd0);
      check("rp_data0", 32'(out_data), 32'd0);

      // Words waiting while reset holds; first fetch right after release.
      push(8'h81); push(8'h82); push(8'h83); push(8'h84); push(8'h85);
      step();
      check("rp_read_held", 32'(read), 32'd0);
      check("rp_reads", 32'(reads - r0), 32'd0);
      reset = 1'b0;
      step();
      check("rel_read", 32'(read), 32'd1);

      // Counter wrap on the 2-bit instance: 1,2,3,0,1.
      for (int i = 0; i < 5; i++) begin
         wait_valid(n);
         deliver("wrap", 8'(8'h81 + i), 8'(i + 1), 2'(i + 1));
      end
      repeat (4) step();
      check("wrap_busy", 32'(busy2), 32'd0);
      check("wrap_valid2", 32'(out_valid2), 32'd0);
      check("wrap_read2", 32'(read2), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
